seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are 2 to 16.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have input in_valid, 1 bit: the operands are valid.
REQ-005 The block SHALL have output in_ready, 1 bit: the block can accept operands.
REQ-006 The block SHALL have input dividend, WIDTH bits: unsigned numerator.
REQ-007 The block SHALL have input divisor, WIDTH bits: unsigned denominator.
REQ-008 The block SHALL have output out_valid, 1 bit: the result is valid.
REQ-009 The block SHALL have input out_ready, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have output quotient, WIDTH bits: unsigned quotient.
REQ-011 The block SHALL have output remainder, WIDTH bits: unsigned remainder.
REQ-012 The block SHALL have output div_zero, 1 bit: divide-by-zero flag, qualified by out_valid.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; an input handshake is a cycle with in_valid=1 and in_ready=1.
REQ-015 On an input handshake the block SHALL latch dividend and divisor, clear the partial remainder, load the iteration counter with WIDTH-1 and go to CALC.
REQ-016 Each CALC cycle SHALL perform one restoring step, MSB first:
- shift the next dividend bit into a WIDTH+1-bit partial remainder;
- subtract divisor;
- if the result is non-negative, keep it and set the quotient bit to 1;
- otherwise restore the previous value and set the quotient bit to 0.
REQ-017 After exactly WIDTH CALC cycles the FSM SHALL enter DONE, and out_valid SHALL be 1 in the cycle that starts WIDTH+1 edges after the handshake edge.
REQ-018 In DONE, out_valid, quotient, remainder and div_zero SHALL hold stable until out_ready=1.
REQ-019 On an output handshake (out_valid=1 and out_ready=1) the FSM SHALL go to IDLE on the next edge, with out_valid deasserted.
REQ-020 Back-to-back operation SHALL NOT be supported; the minimum spacing between input handshakes SHALL be WIDTH+2 cycles.
REQ-021 in_valid in CALC or DONE SHALL be ignored, and the operands latched at the handshake SHALL be unaffected.
REQ-022 Operand changes on the input ports after the handshake SHALL NOT affect the result.
REQ-023 For any divisor != 0, results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-024 For divisor = 0, the result SHALL be quotient = all ones and remainder = dividend.
REQ-025 quotient and remainder SHALL be registered outputs; they SHALL retain the last result in IDLE and are don't-care while out_valid=0.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and drive in_ready=1, out_valid=0, quotient=0, remainder=0 and div_zero=0, and SHALL clear the counter and the partial remainder.
REQ-027 rst SHALL take priority over any handshake in the same cycle.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation with no result presented.

Configuration
REQ-029 Macro SEQ_DIVIDER_DIV_ZERO_EN defined SHALL enable zero detection: a handshake with divisor=0 goes directly to DONE on the next edge, skipping CALC, with quotient all ones, remainder=dividend and div_zero=1.
REQ-030 Macro SEQ_DIVIDER_DIV_ZERO_EN undefined SHALL leave divisor=0 on the normal WIDTH-cycle path with the same quotient and remainder values as REQ-024, and div_zero SHALL be tied to 0.

Verification (WIDTH=4)
REQ-031 The bench SHALL cover: dividend 13, divisor 3 -> out_valid rises 5 edges after the handshake; quotient 4, remainder 1, div_zero 0.
REQ-032 The bench SHALL cover: 15/1 -> quotient 15, remainder 0; then 2/7 -> quotient 0, remainder 2; then 0/5 -> quotient 0, remainder 0.
REQ-033 The bench SHALL cover: 9/0 -> with the macro, out_valid 1 edge after the handshake, quotient 15, remainder 9, div_zero 1; without the macro, out_valid after 5 edges with the same values and div_zero 0.
REQ-034 The bench SHALL cover: 11/2 with out_ready held low for 3 cycles in DONE -> quotient 5 and remainder 1 stable throughout; in_ready stays 0; a new in_valid meanwhile is not accepted.
REQ-035 The bench SHALL cover: rst pulsed on the second CALC cycle of 14/3 -> next cycle IDLE, in_ready 1, out_valid 0, and all outputs 0; a following 14/3 yields quotient 4, remainder 2.
REQ-036 The bench SHALL cover: an exhaustive random sweep of all 256 operand pairs with random out_ready -> every result matches the REQ-023/REQ-024 reference.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider -- sequential restoring divider, one quotient bit per cycle.
//
// Purpose:
//   Unsigned WIDTH-bit division. An input handshake latches the operands.
//   The FSM then runs WIDTH restoring steps, MSB first, and presents the
//   quotient and remainder in DONE until the consumer accepts them.
//   Dividing by zero gives quotient = all ones and remainder = dividend.
//
// Configuration macro:
//   SEQ_DIVIDER_DIV_ZERO_EN -- when defined, a handshake with divisor == 0
//   skips CALC and enters DONE on the next edge with div_zero = 1. When the
//   macro is undefined, divisor == 0 takes the normal WIDTH-cycle path and
//   div_zero is tied to 0.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (IDLE only)
//   dividend   in   WIDTH-bit unsigned numerator
//   divisor    in   WIDTH-bit unsigned denominator
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   quotient   out  WIDTH-bit unsigned quotient (registered)
//   remainder  out  WIDTH-bit unsigned remainder (registered)
//   div_zero   out  divide-by-zero flag, qualified by out_valid
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // dvd_q starts as the dividend. Each step shifts one dividend bit out of
  // the top and one quotient bit in at the bottom, so after WIDTH steps it
  // holds the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // The partial remainder is always below the divisor, so WIDTH bits hold it.
  // The extra bit lives in shifted_s and diff_s.
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  logic             dz_q, dz_d;
`endif

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;

  // One restoring step: bring down the next dividend bit and trial-subtract.
  always_comb begin
    shifted_s = {prem_q, dvd_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    // A clear sign bit means the trial subtraction did not underflow.
    fits_s    = ~diff_s[WIDTH];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          cnt_d  = CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            dz_d    = 1'b0;
          end
`else
          state_d = CALC;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        prem_d = fits_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
        if (WIDTH > 1) begin
          dvd_d = {dvd_q[WIDTH-2:0], fits_s};
        end else begin
          dvd_d = WIDTH'(fits_s);
        end
        if (cnt_q == '0) begin
          // Last step: publish the result into the output registers.
          state_d = DONE;
          quo_d   = dvd_d;
          rem_d   = prem_d;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule
